alu: RTL and testbench

32-bit integer ALU for the MIPS CPU execute stage. It computes ADD, SUB, OR or signed SLT on two 32-bit operands through a zero-latency combinational path that drives the datapath and branch logic. It also provides a clocked result/flag register and an optional sticky overflow flag for exception handling.

---
 rtl/alu.sv | 71 +++++++
 tb/tb_alu.sv | 116 +++++++++++
 2 files changed

// File: rtl/alu.sv
// alu: 32-bit MIPS execute-stage ALU (ADD/SUB/OR/SLT) with a registered result/flag copy.
// Define ALU_OVF_STICKY_EN to build the sticky overflow flag; otherwise ovf_sticky is tied to 0.
module alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  sel,
    input  logic        en,
    input  logic        ovf_clr,
    output logic [31:0] out,
    output logic        zero,
    output logic        ge_than_zero,
    output logic        overflow,
    output logic [31:0] out_q,
    output logic        zero_q,
    output logic        ge_q,
    output logic        ovf_q,
    output logic        ovf_sticky
);
    localparam logic [1:0] ALU_SEL_ADD = 2'b00;
    localparam logic [1:0] ALU_SEL_SUB = 2'b01;
    localparam logic [1:0] ALU_SEL_OR  = 2'b10;

    logic [31:0] sum;
    logic [31:0] diff;
    logic        lt;

    assign sum  = a + b;
    assign diff = a - b;
    // True signed compare, immune to the wrap of a-b.
    assign lt   = $signed(a) < $signed(b);

    always_comb begin
        out          = sel == ALU_SEL_ADD ? sum :
                       sel == ALU_SEL_SUB ? diff :
                       sel == ALU_SEL_OR  ? (a | b) : {31'd0, lt};
        overflow     = sel == ALU_SEL_ADD && a[31] == b[31] && sum[31] != a[31];
        zero         = out == 32'd0;
        ge_than_zero = ~out[31];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= 32'd0;
            zero_q <= 1'b0;
            ge_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (en) begin
            out_q  <= out;
            zero_q <= zero;
            ge_q   <= ge_than_zero;
            ovf_q  <= overflow;
        end
    end

`ifdef ALU_OVF_STICKY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_sticky <= 1'b0;
        else if (ovf_clr)
            ovf_sticky <= 1'b0;
        else if (en && overflow)
            ovf_sticky <= 1'b1;
    end
`else
    logic unused_clr;
    assign unused_clr = ovf_clr;
    assign ovf_sticky = 1'b0;
`endif
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for alu; sticky expectations follow ALU_OVF_STICKY_EN.
module tb_alu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [1:0]  sel = 2'b00;
    logic        en = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [31:0] out, out_q;
    logic        zero, ge_than_zero, overflow, zero_q, ge_q, ovf_q, ovf_sticky;
    int          vectors = 0;
    int          errors = 0;

`ifdef ALU_OVF_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    alu dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel), .en(en), .ovf_clr(ovf_clr),
        .out(out), .zero(zero), .ge_than_zero(ge_than_zero), .overflow(overflow),
        .out_q(out_q), .zero_q(zero_q), .ge_q(ge_q), .ovf_q(ovf_q), .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic comb(input logic [1:0] s, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] e_out, input logic e_zero, input logic e_ge,
                        input logic e_ovf, input string tag);
        sel = s; a = x; b = y;
        #1;
        chk({tag, ".out"}, out, e_out);
        chk({tag, ".zero"}, {31'd0, zero}, {31'd0, e_zero});
        chk({tag, ".ge"}, {31'd0, ge_than_zero}, {31'd0, e_ge});
        chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, e_ovf});
    endtask

    task automatic regs(input logic [31:0] e_out, input logic e_zero, input logic e_ge,
                        input logic e_ovf, input logic e_st, input string tag);
        chk({tag, ".out_q"}, out_q, e_out);
        chk({tag, ".zero_q"}, {31'd0, zero_q}, {31'd0, e_zero});
        chk({tag, ".ge_q"}, {31'd0, ge_q}, {31'd0, e_ge});
        chk({tag, ".ovf_q"}, {31'd0, ovf_q}, {31'd0, e_ovf});
        chk({tag, ".sticky"}, {31'd0, ovf_sticky}, {31'd0, e_st});
    endtask

    initial begin
        #2;
        regs(32'd0, 0, 0, 0, 0, "reset");
        @(negedge clk);
        rst_n = 1'b1;
        comb(2'b00, 32'd1, 32'd1, 32'd2, 0, 1, 0, "add_1_1");
        comb(2'b00, 32'h7fffffff, 32'd1, 32'h80000000, 0, 0, 1, "add_ovf");
        comb(2'b00, 32'd1, 32'h7fffffff, 32'h80000000, 0, 0, 1, "add_ovf_swap");
        comb(2'b00, 32'h80000000, 32'h80000000, 32'd0, 1, 1, 1, "add_neg_ovf");
        comb(2'b01, 32'd123, 32'd123, 32'd0, 1, 1, 0, "sub_eq");
        comb(2'b01, 32'd123, 32'd234, 32'hffffff91, 0, 0, 0, "sub_neg");
        comb(2'b01, 32'd0, 32'h80000000, 32'h80000000, 0, 0, 0, "sub_wrap1");
        comb(2'b01, 32'hfffffffe, 32'h7fffffff, 32'h7fffffff, 0, 1, 0, "sub_wrap2");
        comb(2'b10, 32'h98765432, 32'habcdef12, 32'hbbffff32, 0, 0, 0, "or");
        comb(2'b11, 32'd1, 32'd2, 32'd1, 0, 1, 0, "slt_lt");
        comb(2'b11, 32'd2, 32'd2, 32'd0, 1, 1, 0, "slt_eq");
        comb(2'b11, 32'd3, 32'd2, 32'd0, 1, 1, 0, "slt_gt");
        comb(2'b11, 32'h80000000, 32'd1, 32'd1, 0, 1, 0, "slt_min");
        comb(2'b11, 32'h7fffffff, 32'h80000000, 32'd0, 1, 1, 0, "slt_max");
        regs(32'd0, 0, 0, 0, 0, "hold_en0");
        // overflow capture
        @(negedge clk);
        sel = 2'b00; a = 32'h7fffffff; b = 32'd1; en = 1'b1;
        @(posedge clk); #1;
        regs(32'h80000000, 0, 0, 1, STICKY, "cap_ovf");
        @(negedge clk);
        a = 32'd1; en = 1'b0;
        @(posedge clk); #1;
        regs(32'h80000000, 0, 0, 1, STICKY, "hold");
        @(negedge clk);
        sel = 2'b01; a = 32'd5; b = 32'd5; en = 1'b1;
        @(posedge clk); #1;
        regs(32'd0, 1, 1, 0, STICKY, "cap_zero");
        // clear wins over a coincident overflow
        @(negedge clk);
        sel = 2'b00; a = 32'h7fffffff; b = 32'd1; ovf_clr = 1'b1;
        @(posedge clk); #1;
        regs(32'h80000000, 0, 0, 1, 0, "clr_prio");
        @(negedge clk);
        ovf_clr = 1'b0;
        @(posedge clk); #1;
        regs(32'h80000000, 0, 0, 1, STICKY, "reset_arm");
        #2;
        rst_n = 1'b0;
        #1;
        regs(32'd0, 0, 0, 0, 0, "async_rst");
        @(posedge clk); #1;
        regs(32'd0, 0, 0, 0, 0, "rst_hold");
        @(negedge clk);
        rst_n = 1'b1; a = 32'd1; b = 32'd1;
        @(posedge clk); #1;
        regs(32'd2, 0, 1, 0, 0, "first_cap");
        @(negedge clk);
        ovf_clr = 1'b1; a = 32'h7fffffff;
        @(posedge clk); #1;
        regs(32'h80000000, 0, 0, 1, 0, "clr_only");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
